icache_line_fetch: RTL

Direct-mapped instruction cache with line-fill controller. It sits directly upstream of the instruction fetch queue and serves 128-bit (4-instruction) lines. Request side: the queue's fetch PC, read enable and abort. Response side: a line plus a one-cycle valid strobe into the queue's FIFO write port. On a miss it fills the line from a word-serial memory interface.

---
 rtl/icache_line_fetch.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/icache_line_fetch.sv
// Direct-mapped instruction cache serving 128-bit lines to the fetch queue.
// Misses are filled from a word-serial memory port; the filled line is returned from RESP.
module icache_line_fetch #(
    parameter int LINES = 16,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         rd_en,
    input  logic [31:0]  pc_in,
    input  logic         abort,
    output logic [127:0] dout,
    output logic         dout_valid,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ack,
    input  logic [31:0]  mem_rdata,
    output logic [15:0]  hit_cnt,
    output logic [15:0]  miss_cnt
);

    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t state, state_next;

    logic [LINES-1:0]  line_valid;
    logic [TAG_W-1:0]  line_tag  [LINES];
    logic [127:0]      line_data [LINES];
    logic [3:0][31:0]  fill_buf;
    logic [1:0]        beat;
    logic              abort_pend;
    logic [27:0]       fill_line;

    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]  req_tag, fill_tag;
    logic              hit;
    logic              do_hit, do_miss, do_beat, do_install, do_resp;
    logic              unused_offset;

    assign req_idx       = pc_in[IDX_W+3:4];
    assign req_tag       = pc_in[31:IDX_W+4];
    assign fill_idx      = fill_line[IDX_W-1:0];
    assign fill_tag      = fill_line[27:IDX_W];
    assign hit           = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
    assign unused_offset = ^pc_in[3:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_hit     = 1'b0;
        do_miss    = 1'b0;
        do_beat    = 1'b0;
        do_install = 1'b0;
        do_resp    = 1'b0;
        case (state)
            IDLE: begin
                if (rd_en && !abort) begin
                    if (hit) begin
                        do_hit = 1'b1;
                    end else begin
                        do_miss    = 1'b1;
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                if (mem_ack) begin
                    do_beat = 1'b1;
                    if (beat == 2'd3) begin
                        do_install = 1'b1;
                        state_next = (abort_pend || abort) ? IDLE : RESP;
                    end
                end
            end
            RESP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (rd_en) begin
                    do_resp    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            line_valid <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            beat       <= '0;
            abort_pend <= 1'b0;
            fill_line  <= '0;
        end else begin
            dout_valid <= 1'b0;
            if (do_hit) begin
                dout       <= line_data[req_idx];
                dout_valid <= 1'b1;
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 16'd1;
            end
            if (do_miss) begin
                fill_line <= pc_in[31:4];
                mem_req   <= 1'b1;
                mem_addr  <= {pc_in[31:4], 4'b0000};
                beat      <= '0;
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 16'd1;
            end
            if (do_beat) begin
                beat     <= beat + 2'd1;
                mem_addr <= mem_addr + 32'd4;
            end
            // An abort during a fill is remembered so the completed line is installed but not returned.
            if (do_install) begin
                line_valid[fill_idx] <= 1'b1;
                mem_req              <= 1'b0;
                abort_pend           <= 1'b0;
            end else if (state == FILL && abort) begin
                abort_pend <= 1'b1;
            end
            if (do_resp) begin
                dout       <= fill_buf;
                dout_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (do_beat) fill_buf[beat] <= mem_rdata;
            if (do_install) begin
                line_tag[fill_idx]  <= fill_tag;
                line_data[fill_idx] <= {mem_rdata, fill_buf[2], fill_buf[1], fill_buf[0]};
            end
        end
    end

endmodule
